// File: rtl/trace_pkg.sv
// Shared constants for the commit-trace transmitter: record kinds, word count, record layout.
// Define TRACE_TIMESTAMP_EN to append a 32-bit capture-cycle timestamp word to every record.
package trace_pkg;

    localparam logic KIND_GRF = 1'b0;
    localparam logic KIND_DM  = 1'b1;

`ifdef TRACE_TIMESTAMP_EN
    localparam int TRACE_WORDS = 4;
`else
    localparam int TRACE_WORDS = 3;
`endif

    // Record layout, LSB first: data, address/register, pc, [timestamp], kind.
    localparam int OFF_DATA = 0;
    localparam int OFF_ADDR = 32;
    localparam int OFF_PC   = 64;
`ifdef TRACE_TIMESTAMP_EN
    localparam int OFF_TS   = 96;
    localparam int OFF_KIND = 128;
`else
    localparam int OFF_KIND = 96;
`endif
    localparam int REC_W = OFF_KIND + 1;

    localparam int                IDX_W    = 2;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(TRACE_WORDS - 1);

endpackage

// File: rtl/commit_trace_tx_if.sv
// Capture taps from the core plus the outbound trace word stream and status.
// master = transmitter side, slave = core/consumer side.
interface commit_trace_tx_if #(
    parameter int PTR_W = 3
);
    logic             trace_en;
    logic [31:0]      pc_i;
    logic             grf_we;
    logic [4:0]       grf_addr;
    logic [31:0]      grf_wd;
    logic             dm_we;
    logic [31:0]      dm_addr;
    logic [31:0]      dm_wd;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_kind;
    logic             out_last;
    logic [PTR_W:0]   fifo_count;
    logic             overflow;
    logic [7:0]       drop_cnt;

    modport master (
        input  trace_en, pc_i, grf_we, grf_addr, grf_wd, dm_we, dm_addr, dm_wd, out_ready,
        output out_valid, out_data, out_kind, out_last, fifo_count, overflow, drop_cnt
    );

    modport slave (
        output trace_en, pc_i, grf_we, grf_addr, grf_wd, dm_we, dm_addr, dm_wd, out_ready,
        input  out_valid, out_data, out_kind, out_last, fifo_count, overflow, drop_cnt
    );
endinterface

// File: rtl/trace_fifo.sv
// Record FIFO: synchronous write, combinational head read, full/empty/count.
// Caller guarantees push only when not full or when popping in the same cycle.
module trace_fifo #(
    parameter  int W     = 97,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [W-1:0]     i_wdat,
    input  logic             i_pop,
    output logic [W-1:0]     o_rdat,
    output logic             o_full,
    output logic             o_empty,
    output logic [PTR_W:0]   o_count
);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdat  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/commit_trace_tx.sv
// Commit-trace transmitter: captures GRF/DM writes into a record FIFO and streams each record as 32-bit words.
// Head word valid the cycle after capture; words hold under backpressure; TRACE_TIMESTAMP_EN adds a timestamp word.
module commit_trace_tx
    import trace_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    commit_trace_tx_if.master   trace_bus
);

    logic             w_dm_evt;
    logic             w_grf_evt;
    logic             w_push_req;
    logic             w_push;
    logic             w_pop;
    logic             w_xfer;
    logic             w_last;
    logic             w_full;
    logic             w_empty;
    logic [PTR_W:0]   w_count;
    logic [REC_W-1:0] w_rec;
    logic [REC_W-1:0] w_head;
    logic [1:0]       w_drop_n;
    logic [8:0]       w_drop_sum;
    logic [31:0]      w_out_dat;
    logic             w_out_kind;
    logic             w_out_last;

    logic [IDX_W-1:0] r_word_idx;
    logic             r_overflow;
    logic [7:0]       r_drop_cnt;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]      r_cycle;
`endif

    // A DM write wins the single push slot; a concurrent real GRF write is lost.
    assign w_dm_evt   = trace_bus.trace_en & trace_bus.dm_we;
    assign w_grf_evt  = trace_bus.trace_en & trace_bus.grf_we & (trace_bus.grf_addr != 5'd0);
    assign w_push_req = w_dm_evt | w_grf_evt;

    assign w_xfer = ~w_empty & trace_bus.out_ready;
    assign w_last = (r_word_idx == LAST_IDX);
    assign w_pop  = w_xfer & w_last;
    assign w_push = w_push_req & (~w_full | w_pop);

    assign w_drop_n   = 2'(w_dm_evt & w_grf_evt) + 2'(w_push_req & w_full & ~w_pop);
    assign w_drop_sum = {1'b0, r_drop_cnt} + {7'b0, w_drop_n};

    always_comb begin
        w_rec                  = '0;
        w_rec[OFF_KIND]        = w_dm_evt ? KIND_DM : KIND_GRF;
        w_rec[OFF_PC +: 32]    = trace_bus.pc_i;
        w_rec[OFF_ADDR +: 32]  = w_dm_evt ? trace_bus.dm_addr : {27'b0, trace_bus.grf_addr};
        w_rec[OFF_DATA +: 32]  = w_dm_evt ? trace_bus.dm_wd : trace_bus.grf_wd;
`ifdef TRACE_TIMESTAMP_EN
        w_rec[OFF_TS +: 32]    = r_cycle;
`endif
    end

    trace_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdat  (w_rec),
        .i_pop   (w_pop),
        .o_rdat  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word_idx <= '0;
        end else if (w_xfer) begin
            r_word_idx <= w_last ? '0 : r_word_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_drop_n != 2'd0) begin
                r_overflow <= 1'b1;
            end
            r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end
`endif

    // Outputs derive combinationally from FIFO state so an async reset clears them at once.
    always_comb begin
        w_out_dat  = '0;
        w_out_kind = 1'b0;
        w_out_last = 1'b0;
        if (!w_empty) begin
            w_out_kind = w_head[OFF_KIND];
            w_out_last = w_last;
            case (r_word_idx)
                2'd0:    w_out_dat = w_head[OFF_PC +: 32];
                2'd1:    w_out_dat = w_head[OFF_ADDR +: 32];
                2'd2:    w_out_dat = w_head[OFF_DATA +: 32];
`ifdef TRACE_TIMESTAMP_EN
                default: w_out_dat = w_head[OFF_TS +: 32];
`else
                default: w_out_dat = '0;
`endif
            endcase
        end
    end

    assign trace_bus.out_valid  = ~w_empty;
    assign trace_bus.out_data   = w_out_dat;
    assign trace_bus.out_kind   = w_out_kind;
    assign trace_bus.out_last   = w_out_last;
    assign trace_bus.fifo_count = w_count;
    assign trace_bus.overflow   = r_overflow;
    assign trace_bus.drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_commit_trace_tx.sv
// Bench for commit_trace_tx (default 3-word build): directed scenarios plus random traffic,
// checked by a record-level reference model feeding a word scoreboard.
module tb_commit_trace_tx;
    import trace_pkg::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;

    commit_trace_tx_if #(.PTR_W(3)) bus ();

    commit_trace_tx #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .trace_bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: buffered record count, word position of the head record, drop accounting.
    int         m_count = 0;
    int         m_widx  = 0;
    int         m_drops = 0;
    bit         m_ovf   = 1'b0;
    logic [33:0] exp_q[$];   // {kind, last, word}

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_rec(bit kind, logic [31:0] pc, logic [31:0] a, logic [31:0] d);
        exp_q.push_back({kind, 1'b0, pc});
        exp_q.push_back({kind, 1'b0, a});
        exp_q.push_back({kind, 1'b1, d});
    endtask

    task automatic model_step();
        bit xfer;
        bit pop;
        bit dm;
        bit grf;
        int drops;
        drops = 0;
        xfer  = (m_count > 0) && bus.out_ready;
        pop   = xfer && (m_widx == 2);
        if (xfer) m_widx = pop ? 0 : m_widx + 1;
        if (pop) m_count--;
        dm  = bus.trace_en && bus.dm_we;
        grf = bus.trace_en && bus.grf_we && (bus.grf_addr != 5'd0);
        if (dm && grf) drops++;
        if (dm || grf) begin
            if (m_count < DEPTH) begin
                m_count++;
                if (dm) push_rec(1'b1, bus.pc_i, bus.dm_addr, bus.dm_wd);
                else    push_rec(1'b0, bus.pc_i, {27'b0, bus.grf_addr}, bus.grf_wd);
            end else begin
                drops++;
            end
        end
        m_drops = (m_drops + drops > 255) ? 255 : m_drops + drops;
        if (drops > 0) m_ovf = 1'b1;
    endtask

    task automatic clear_model();
        m_count = 0;
        m_widx  = 0;
        m_drops = 0;
        m_ovf   = 1'b0;
        exp_q.delete();
    endtask

    always @(posedge clk) begin
        if (!reset) model_step();
    end

    // Monitor: status every cycle, and each transferred word against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            check("out_valid", 32'(bus.out_valid), 32'(m_count > 0));
            check("fifo_count", 32'(bus.fifo_count), m_count);
            check("overflow", 32'(bus.overflow), 32'(m_ovf));
            check("drop_cnt", 32'(bus.drop_cnt), m_drops);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h, expected no word at %0t", bus.out_data, $time);
                end else begin
                    logic [33:0] e;
                    e = exp_q.pop_front();
                    check("word_data", bus.out_data, e[31:0]);
                    check("word_kind", 32'(bus.out_kind), 32'(e[33]));
                    check("word_last", 32'(bus.out_last), 32'(e[32]));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.trace_en = 1'b0;
        bus.pc_i     = '0;
        bus.grf_we   = 1'b0;
        bus.grf_addr = '0;
        bus.grf_wd   = '0;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wd    = '0;
    endtask

    task automatic grf_evt(logic [31:0] pc, logic [4:0] a, logic [31:0] d);
        idle();
        bus.trace_en = 1'b1;
        bus.pc_i     = pc;
        bus.grf_we   = 1'b1;
        bus.grf_addr = a;
        bus.grf_wd   = d;
    endtask

    task automatic drain();
        idle();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 200 && (bus.fifo_count != 0 || exp_q.size() != 0); i++) step();
        check("drain_fifo_empty", 32'(bus.fifo_count), 32'd0);
        check("drain_sb_empty", exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        bus.out_ready = 1'b0;
        #1 reset = 1'b1;
        #2;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_kind", 32'(bus.out_kind), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // GRF write
        grf_evt(32'h0000_3000, 5'd8, 32'h0000_1234);
        bus.out_ready = 1'b1;
        step();
        idle();
        check("grf_w0_data", bus.out_data, 32'h0000_3000);
        check("grf_w0_kind", 32'(bus.out_kind), 32'd0);
        drain();

        // DM write
        bus.trace_en = 1'b1;
        bus.pc_i     = 32'h0000_3004;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 32'h0000_0010;
        bus.dm_wd    = 32'hDEAD_BEEF;
        step();
        idle();
        check("dm_w0_data", bus.out_data, 32'h0000_3004);
        check("dm_w0_kind", 32'(bus.out_kind), 32'd1);
        drain();

        // $0 writes are filtered, not dropped
        grf_evt(32'h0000_3008, 5'd0, 32'h1111_1111);
        step();
        idle();
        check("zero_fifo_count", 32'(bus.fifo_count), 32'd0);
        check("zero_drop_cnt", 32'(bus.drop_cnt), 32'd0);

        // Dual write: DM kept, GRF dropped
        grf_evt(32'h0000_300C, 5'd3, 32'h2222_2222);
        bus.dm_we   = 1'b1;
        bus.dm_addr = 32'h0000_0020;
        bus.dm_wd   = 32'h0000_0055;
        step();
        idle();
        check("dual_fifo_count", 32'(bus.fifo_count), 32'd1);
        check("dual_drop_cnt", 32'(bus.drop_cnt), 32'd1);
        check("dual_overflow", 32'(bus.overflow), 32'd1);
        check("dual_kind", 32'(bus.out_kind), 32'd1);
        drain();

        // Backpressure and overflow
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            grf_evt(32'h100 + 32'(4 * i), 5'(i + 1), 32'hA000 + 32'(i));
            step();
        end
        idle();
        check("bp_fifo_count", 32'(bus.fifo_count), 32'd8);
        check("bp_drop_cnt", 32'(bus.drop_cnt), 32'd2);
        check("bp_out_data", bus.out_data, 32'h100);
        repeat (3) step();
        check("bp_frozen_data", bus.out_data, 32'h100);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            check("bp_no_gap", 32'(bus.out_valid), 32'd1);
            step();
        end
        check("bp_drained", 32'(bus.fifo_count), 32'd0);

        // Full FIFO: push accepted on the edge the head record completes
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            grf_evt(32'h200 + 32'(4 * i), 5'd7, 32'hB000 + 32'(i));
            step();
        end
        idle();
        check("fp_full", 32'(bus.fifo_count), 32'd8);
        bus.out_ready = 1'b1;
        step();
        step();
        grf_evt(32'h0000_0300, 5'd9, 32'h0000_ABCD);
        step();
        idle();
        check("fp_count_kept", 32'(bus.fifo_count), 32'd8);
        check("fp_no_drop", 32'(bus.drop_cnt), 32'd2);
        drain();

        // Reset in the middle of a record
        bus.out_ready = 1'b0;
        grf_evt(32'h0000_0400, 5'd5, 32'h0000_0044);
        step();
        idle();
        bus.out_ready = 1'b1;
        step();
        step();
        #3 reset = 1'b1;
        clear_model();
        #1;
        check("mr_out_valid", 32'(bus.out_valid), 32'd0);
        check("mr_fifo_count", 32'(bus.fifo_count), 32'd0);
        check("mr_out_data", bus.out_data, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) step();
        check("mr_stay_empty", 32'(bus.out_valid), 32'd0);
        grf_evt(32'h0000_0500, 5'd4, 32'h0000_0055);
        step();
        idle();
        check("mr_new_w0", bus.out_data, 32'h0000_0500);
        drain();

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            bus.trace_en  = ($urandom % 8) != 0;
            bus.pc_i      = $urandom;
            bus.grf_we    = $urandom % 2;
            bus.grf_addr  = 5'($urandom % 32);
            bus.grf_wd    = $urandom;
            bus.dm_we     = ($urandom % 4) == 0;
            bus.dm_addr   = $urandom;
            bus.dm_wd     = $urandom;
            bus.out_ready = ($urandom % 10) < 6;
            step();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
